// File: rtl/err_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | err_pkg: shared types and constants for the OR-merge error-term datapath    |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
package err_pkg;

   localparam int C_N_DEF       = 16;
   localparam int P             = C_N_DEF / 2;
   localparam int W             = 2 * C_N_DEF;
   localparam int C_OUT_LSB_DEF = 20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int pairs);
      return (pairs > 1) ? $clog2(pairs) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/err_pair_term.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | err_pair_term: term dropped when OR-merging partial-product rows 2k, 2k+1  |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module err_pair_term
   import err_pkg::*;
#(
   parameter int N  = C_N_DEF,
   parameter int KW = cnt_width(C_N_DEF / 2)
) (
   input  logic [N-1:0]   i_a,
   input  logic [N-1:0]   i_b,
   input  logic [KW-1:0]  i_k,
   output logic [2*N-1:0] o_term
);

   logic [2*N-1:0] w_a_ext;
   logic [2*N-1:0] w_adj;
   logic           w_pair_on;

   // Rows 2k and 2k+1 overlap only where A has two adjacent ones.
   always_comb begin
      w_a_ext   = {{N{1'b0}}, i_a};
      w_adj     = w_a_ext & (w_a_ext << 1);
      w_pair_on = i_b[{i_k, 1'b0}] & i_b[{i_k, 1'b1}];
      o_term    = w_pair_on ? (w_adj << {i_k, 1'b0}) : '0;
   end

endmodule
`default_nettype wire

// File: rtl/err_term_accum.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | err_term_accum: sums the OR-merge dropped terms one pair per cycle          |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module err_term_accum
   import err_pkg::*;
#(
   parameter int N       = C_N_DEF,
   parameter int OUT_LSB = C_OUT_LSB_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   abort,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N-1:0]           in_a,
   input  logic [N-1:0]           in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*N-1:0]         out_err,
   output logic [2*N-OUT_LSB-1:0] out_err_hi
);

   localparam int              C_PAIRS  = N / 2;
   localparam int              C_W      = 2 * N;
   localparam int              C_KW     = cnt_width(C_PAIRS);
   localparam logic [C_KW-1:0] C_K_LAST = C_KW'(C_PAIRS - 1);

   state_t          r_state;
   state_t          w_state_next;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic [C_KW-1:0] r_k;
   logic [C_W-1:0]  r_acc;
   logic [C_W-1:0]  w_term;
   logic [C_W-1:0]  w_err;

   err_pair_term #(
      .N  (N),
      .KW (C_KW)
   ) u_pair_term (
      .i_a    (r_a),
      .i_b    (r_b),
      .i_k    (r_k),
      .o_term (w_term)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (abort) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (in_valid)          w_state_next = RUN;
            RUN:     if (r_k == C_K_LAST)   w_state_next = DONE;
            DONE:    if (out_ready)         w_state_next = IDLE;
            default:                        w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_k   <= '0;
         r_acc <= '0;
      end else if (abort) begin
         r_k <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a   <= in_a;
                  r_b   <= in_b;
                  r_acc <= '0;
                  r_k   <= '0;
               end
            end
            RUN: begin
               r_acc <= r_acc + w_term;
               r_k   <= (r_k == C_K_LAST) ? '0 : r_k + C_KW'(1);
            end
            default: ;
         endcase
      end
   end

   // Result is masked outside DONE so partial sums never reach the adder stage.
   always_comb begin
      in_ready   = (r_state == IDLE);
      out_valid  = (r_state == DONE);
      w_err      = out_valid ? r_acc : '0;
      out_err    = w_err;
      out_err_hi = w_err[C_W-1:OUT_LSB];
   end

endmodule
`default_nettype wire

// File: tb/tb_err_term_accum.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_err_term_accum: random + directed bench against a transaction model     |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module tb_err_term_accum;

   localparam int P = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        abort;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_err;
   logic [11:0] out_err_hi;

   int          checks = 0;
   int          errors = 0;

   int          m_run  = 0;
   bit          m_done = 1'b0;
   logic [31:0] m_err  = '0;
   logic [31:0] lit_err = '0;
   bit          lit_on  = 1'b0;

   always #5 clk = ~clk;

   err_term_accum dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .abort      (abort),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_err    (out_err),
      .out_err_hi (out_err_hi)
   );

   // Exact sum of row pairs minus their OR-merged value.
   function automatic logic [31:0] model_err(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] s;
      logic [31:0] p0;
      logic [31:0] p1;
      s = '0;
      for (int k = 0; k < P; k++) begin
         p0 = b[2*k]   ? ({16'd0, a} << (2*k))     : 32'd0;
         p1 = b[2*k+1] ? ({16'd0, a} << (2*k + 1)) : 32'd0;
         s  = s + ((p0 + p1) - (p0 | p1));
      end
      return s;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || abort) begin
         m_run  = 0;
         m_done = 1'b0;
      end else if (m_run > 0) begin
         m_run--;
         if (m_run == 0) m_done = 1'b1;
      end else if (m_done) begin
         if (out_ready) m_done = 1'b0;
      end else if (in_valid) begin
         m_run = P;
         m_err = model_err(in_a, in_b);
      end
   end

   initial forever begin
      @(negedge clk);
      chk("in_ready", {31'd0, in_ready}, {31'd0, (m_run == 0 && !m_done)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
      if (m_done) begin
         chk("out_err", out_err, m_err);
         chk("out_err_hi", {20'd0, out_err_hi}, {20'd0, m_err[31:20]});
         if (lit_on) begin
            chk("lit_out_err", out_err, lit_err);
            chk("lit_out_err_hi", {20'd0, out_err_hi}, {20'd0, lit_err[31:20]});
         end
      end
      if (!rst_n) begin
         chk("rst_out_err", out_err, 32'd0);
         chk("rst_out_err_hi", {20'd0, out_err_hi}, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (in_ready !== 1'b1) begin
         tick();
         n++;
         if (n > 40) begin
            $display("FAIL wait_in_ready: actual timeout required in_ready=1");
            $fatal(1, "in_ready timeout");
         end
      end
   endtask

   task automatic start(input logic [15:0] a, input logic [15:0] b);
      wait_ready();
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
   endtask

   task automatic op(input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp, input int hold);
      int n;
      lit_err = exp;
      lit_on  = 1'b1;
      start(a, b);
      n = 0;
      while (out_valid !== 1'b1) begin
         tick();
         n++;
         if (n > 20) begin
            $display("FAIL wait_out_valid: actual timeout required out_valid=1");
            $fatal(1, "out_valid timeout");
         end
      end
      repeat (hold) begin
         in_valid = 1'b1;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      lit_on    = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      abort     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_a      = '0;
      in_b      = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      op(16'hFFFF, 16'h0003, 32'h0000FFFE, 0);
      op(16'hFFFF, 16'hFFFF, 32'h55545556, 2);
      op(16'h0003, 16'h000C, 32'h00000008, 1);
      op(16'h0001, 16'hFFFF, 32'h00000000, 0);
      op(16'hFFFF, 16'h0003, 32'h0000FFFE, 5);

      start(16'hFFFF, 16'hFFFF);
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      op(16'hFFFF, 16'h0003, 32'h0000FFFE, 0);

      start(16'hFFFF, 16'hFFFF);
      repeat (2) tick();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      op(16'hFFFF, 16'h0003, 32'h0000FFFE, 0);

      for (int i = 0; i < 1500; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
         in_b      = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         out_ready = ($urandom_range(0, 2) == 0);
         abort     = ($urandom_range(0, 49) == 0);
         tick();
      end

      abort     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (12) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
